// File: rtl/insn_encoder_loader_if.sv
// ---------------------------------------------------------------------------
// insn_encoder_loader_if
// Groups the structured-instruction input channel (valid/ready plus fields)
// and the instruction-memory write bus of the program loader.
//   in_valid / in_ready       : instruction handshake
//   in_op, in_rd, in_rs1,
//   in_rs2, in_imm            : structured instruction fields
//   imem_we, imem_addr,
//   imem_wdata                : registered instruction-memory write port
// master : the instruction source (also observes the write bus)
// slave  : the loader
// ---------------------------------------------------------------------------
interface insn_encoder_loader_if #(
    parameter int AW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [1:0]    in_rd;
    logic [1:0]    in_rs1;
    logic [1:0]    in_rs2;
    logic [15:0]   in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/insn_encoder_loader.sv
// ---------------------------------------------------------------------------
// insn_encoder_loader
// Program loader for the attopu instruction memory. Accepts structured
// instructions, range-checks them, encodes legal ones into the 16-bit format
// and writes them to consecutive addresses during a load session.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : pulse, begin/restart a session at start_addr
//   start_addr      : first write address (sampled on start)
//   finish          : pulse, end the session
//   bus (slave)     : instruction handshake + instruction-memory write bus
//   busy/done/err   : session state LOAD / DONE / ERROR (levels)
//   err_code        : 01 reserved op, 10 address range, 11 branch range
//   count           : words written this session
// ---------------------------------------------------------------------------
module insn_encoder_loader #(
    parameter int AW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [AW-1:0]          start_addr,
    input  logic                   finish,
    insn_encoder_loader_if.slave   bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [AW:0]            count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_count;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_wdata;
    logic [1:0]    r_err_code;

    logic          w_accept;
    logic          w_legal;
    logic [15:0]   w_word;
    logic [1:0]    w_code;

    // Ready depends on registered state only, never on in_valid.
    assign bus.in_ready = (r_state == LOAD);
    assign w_accept     = bus.in_valid && (r_state == LOAD);

    // Encoder and range checker. Unlisted bits are forced to zero.
    always_comb begin
        w_word  = 16'd0;
        w_legal = 1'b1;
        w_code  = 2'b00;
        case (bus.in_op)
            3'd0: w_word = {2'b00, 1'b0, bus.in_rd, bus.in_rs1, bus.in_rs2, 7'd0};
            3'd1, 3'd3: begin
                w_word = {(bus.in_op == 3'd1) ? 2'b01 : 2'b10, 1'b0, bus.in_rd,
                          bus.in_imm[10:0]};
                if (bus.in_imm[15:11] != 5'd0) begin
                    w_legal = 1'b0;
                    w_code  = 2'b10;
                end
            end
            3'd2: w_word = {2'b01, 1'b1, bus.in_rd, bus.in_rs1, 9'd0};
            3'd4: w_word = {2'b10, 1'b1, bus.in_rd, bus.in_rs1, bus.in_rs2, 7'd0};
            3'd5: begin
                w_word = {2'b11, 1'b0, 2'b00, bus.in_imm[10:0]};
                // Offset fits in 11-bit two's complement only if bits 15..10
                // are a pure sign extension.
                if (!((&bus.in_imm[15:10]) || (~|bus.in_imm[15:10]))) begin
                    w_legal = 1'b0;
                    w_code  = 2'b11;
                end
            end
            3'd6: w_word = {2'b11, 1'b1, 2'b00, bus.in_rs1, 9'd0};
            default: begin
                w_legal = 1'b0;
                w_code  = 2'b01;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 16'd0;
            r_err_code <= 2'b00;
        end else begin
            // Write strobe is a one-cycle pulse; address/data hold otherwise.
            r_we <= 1'b0;
            if (start) begin
                r_state    <= LOAD;
                r_ptr      <= start_addr;
                r_count    <= '0;
                r_err_code <= 2'b00;
            end else if (r_state == LOAD) begin
                if (w_accept && w_legal) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_ptr;
                    r_wdata <= w_word;
                    r_count <= r_count + (AW + 1)'(1);
                    // Last address consumed: stop instead of wrapping.
                    if (r_ptr == {AW{1'b1}}) begin
                        r_state <= DONE;
                    end else begin
                        r_ptr <= r_ptr + AW'(1);
                        if (finish) begin
                            r_state <= DONE;
                        end
                    end
                end else if (w_accept) begin
                    r_err_code <= w_code;
                    r_state    <= ERROR;
                end else if (finish) begin
                    r_state <= DONE;
                end
            end
        end
    end

    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign busy           = (r_state == LOAD);
    assign done           = (r_state == DONE);
    assign err            = (r_state == ERROR);
    assign err_code       = r_err_code;
    assign count          = r_count;
endmodule
